// File: rtl/pipe_skid_reg.sv
// ---------------------------------------------------------------------------
// pipe_skid_reg
//   Two-entry pipeline register with a skid slot. in_ready is decoded from
//   the registered state only, so there is no combinational path from
//   out_ready back to in_ready.
//
//   The entry in main drives out_data. When a new beat arrives while main is
//   stalled, the beat goes into skid. When main drains, skid moves up into
//   main.
//
// Ports
//   clk        : single clock; all state updates on its rising edge
//   reset      : synchronous, active-low reset
//   flush      : synchronous discard of all held entries
//   in_valid   : upstream offers in_data this cycle
//   in_data    : upstream payload, WIDTH bits
//   in_ready   : block accepts in_data this cycle
//   out_valid  : out_data holds a valid entry
//   out_data   : downstream payload, WIDTH bits (main entry)
//   out_ready  : downstream consumes out_data this cycle
//   occupancy  : number of entries held, 0..2
//
// state    | meaning
// ---------+--------------------------------------------
// ST_EMPTY | nothing held, out_valid = 0
// ST_BUSY  | main holds the head entry, skid is free
// ST_FULL  | main holds the head, skid holds the next one
// ---------------------------------------------------------------------------
module pipe_skid_reg #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       occupancy
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic [WIDTH-1:0] w_main_nxt;
  logic [WIDTH-1:0] w_skid_nxt;
  logic             w_in_xfer;
  logic             w_out_xfer;

  // Outputs depend on the registered state only.
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    occupancy = 2'd0;
    case (r_state)
      ST_EMPTY: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        occupancy = 2'd0;
      end
      ST_BUSY: begin
        in_ready  = 1'b1;
        out_valid = 1'b1;
        occupancy = 2'd1;
      end
      ST_FULL: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        occupancy = 2'd2;
      end
      default: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        occupancy = 2'd0;
      end
    endcase
  end

  assign out_data = r_main;

  always_comb begin
    w_in_xfer  = in_valid & in_ready;
    w_out_xfer = out_valid & out_ready;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;

    case (r_state)
      ST_EMPTY: begin
        if (w_in_xfer) begin
          w_state_nxt = ST_BUSY;
          w_main_nxt  = in_data;
        end
      end
      ST_BUSY: begin
        if (w_in_xfer && w_out_xfer) begin
          w_main_nxt = in_data;
        end else if (w_in_xfer) begin
          // main is stalled, so the new beat parks in skid
          w_state_nxt = ST_FULL;
          w_skid_nxt  = in_data;
        end else if (w_out_xfer) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so in_data is never captured
        if (w_out_xfer) begin
          w_state_nxt = ST_BUSY;
          w_main_nxt  = r_skid;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase

    // Flush wins over every transfer. The entry registers keep their
    // values, so out_data holds stale data while the block is empty.
    if (flush) begin
      w_state_nxt = ST_EMPTY;
      w_main_nxt  = r_main;
      w_skid_nxt  = r_skid;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
    end
  end

endmodule
